iob_modcnt_ctrl: RTL



---
 rtl/iob_modcnt_ctrl_pkg.sv | 21 ++
 rtl/iob_modcnt_ctrl_cnt.sv | 45 ++++
 rtl/iob_modcnt_ctrl.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/iob_modcnt_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// iob_modcnt_ctrl_pkg
//   Shared definitions for the modulo-N counter sequencer:
//     - state encoding of the job sequencer (IDLE / RUN / DONE, 2 bits)
//     - length of the DONE state in cycles and the width of its counter
// -----------------------------------------------------------------------------
package iob_modcnt_ctrl_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // DONE is a fixed-length completion window; done_o is high for all of it.
    localparam int DONE_LEN   = 1;
    localparam int DONE_CNT_W = 2;

endpackage : iob_modcnt_ctrl_pkg

// File: rtl/iob_modcnt_ctrl_cnt.sv
// -----------------------------------------------------------------------------
// iob_modcnt_ctrl_cnt
//   DATA_W-bit modulo counter. Counts 0 .. mod-1 while enabled and wraps to 0.
//   Ports:
//     clk     in   1       clock, rising edge
//     arst_n  in   1       asynchronous active-low reset
//     en      in   1       advance the count this cycle
//     clr     in   1       synchronous clear, dominates en
//     mod     in   DATA_W  period; the wrap value is mod-1
//     count   out  DATA_W  current count (registered)
//     wrap    out  1       count is at mod-1 (combinational)
// -----------------------------------------------------------------------------
module iob_modcnt_ctrl_cnt #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              en,
    input  logic              clr,
    input  logic [DATA_W-1:0] mod,
    output logic [DATA_W-1:0] count,
    output logic              wrap
);

    localparam logic [DATA_W-1:0] ONE = {{(DATA_W-1){1'b0}}, 1'b1};

    // Compare at full DATA_W width; the count never exceeds mod-1, so
    // mod = 2^DATA_W-1 cannot overflow.
    assign wrap = (count == (mod - ONE));

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            if (wrap) begin
                count <= '0;
            end else begin
                count <= count + ONE;
            end
        end
    end

endmodule : iob_modcnt_ctrl_cnt

// File: rtl/iob_modcnt_ctrl.sv
// -----------------------------------------------------------------------------
// iob_modcnt_ctrl
//   Job sequencer for a modulo-N counter. A job (period MOD, repeat count REP)
//   is accepted over cfg_valid_i/cfg_ready_o; the counter then runs REP full
//   periods, pulsing tick_o on every wrap and done_o when the job finishes or
//   is aborted with stop_i.
//   Ports:
//     clk_i        in   1       clock, rising edge
//     arst_n_i     in   1       asynchronous active-low reset
//     cfg_valid_i  in   1       job request valid
//     cfg_ready_o  out  1       idle, can accept a job (combinational)
//     cfg_mod_i    in   DATA_W  period in cycles
//     cfg_rep_i    in   REP_W   number of periods
//     stop_i       in   1       abort the running job
//     pause_i      in   1       hold the counter (only with the macro below)
//     cnt_o        out  DATA_W  current count
//     rep_o        out  REP_W   periods remaining, including the current one
//     tick_o       out  1       wrap cycle indicator (combinational)
//     busy_o       out  1       job running
//     done_o       out  1       one-cycle completion / abort pulse
//   Build option:
//     IOB_MODCNT_CTRL_PAUSE_EN  adds pause_i; while high in RUN the count and
//                               repeat counter hold and tick_o is suppressed.
// -----------------------------------------------------------------------------
module iob_modcnt_ctrl
    import iob_modcnt_ctrl_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int REP_W  = 8
) (
    input  logic              clk_i,
    input  logic              arst_n_i,
    input  logic              cfg_valid_i,
    output logic              cfg_ready_o,
    input  logic [DATA_W-1:0] cfg_mod_i,
    input  logic [REP_W-1:0]  cfg_rep_i,
    input  logic              stop_i,
`ifdef IOB_MODCNT_CTRL_PAUSE_EN
    input  logic              pause_i,
`endif
    output logic [DATA_W-1:0] cnt_o,
    output logic [REP_W-1:0]  rep_o,
    output logic              tick_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam logic [REP_W-1:0]      REP_ONE  = {{(REP_W-1){1'b0}}, 1'b1};
    localparam logic [DONE_CNT_W-1:0] DONE_END = DONE_CNT_W'(DONE_LEN - 1);
    localparam logic [DONE_CNT_W-1:0] DONE_INC = DONE_CNT_W'(1);

    state_t                state;
    logic [DATA_W-1:0]     mod_q;
    logic [REP_W-1:0]      rep_q;
    logic                  busy_q;
    logic                  done_q;
    logic [DONE_CNT_W-1:0] done_cnt;

    logic                  pause;
    logic                  running;
    logic                  wrap;
    logic                  cnt_en;
    logic                  cnt_clr;

`ifdef IOB_MODCNT_CTRL_PAUSE_EN
    assign pause = pause_i;
`else
    assign pause = 1'b0;
`endif

    assign running = (state == RUN);

    // stop_i beats both pause and wrap; a paused wrap is simply deferred
    // because the counter does not advance.
    assign cnt_en  = running & ~stop_i & ~pause;
    assign cnt_clr = ~running | stop_i;

    iob_modcnt_ctrl_cnt #(
        .DATA_W (DATA_W)
    ) u_cnt (
        .clk    (clk_i),
        .arst_n (arst_n_i),
        .en     (cnt_en),
        .clr    (cnt_clr),
        .mod    (mod_q),
        .count  (cnt_o),
        .wrap   (wrap)
    );

    assign cfg_ready_o = (state == IDLE);
    assign tick_o      = cnt_en & wrap;
    assign rep_o       = rep_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state    <= IDLE;
            mod_q    <= '0;
            rep_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            done_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    // stop_i is deliberately not looked at here.
                    if (cfg_valid_i) begin
                        mod_q <= cfg_mod_i;
                        if ((cfg_mod_i == '0) || (cfg_rep_i == '0)) begin
                            // Empty job: report completion without running.
                            state    <= DONE;
                            rep_q    <= '0;
                            done_q   <= 1'b1;
                            done_cnt <= '0;
                        end else begin
                            state  <= RUN;
                            rep_q  <= cfg_rep_i;
                            busy_q <= 1'b1;
                        end
                    end
                end

                RUN: begin
                    if (stop_i) begin
                        state    <= DONE;
                        rep_q    <= '0;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        done_cnt <= '0;
                    end else if (!pause && wrap) begin
                        rep_q <= rep_q - REP_ONE;
                        if (rep_q == REP_ONE) begin
                            state    <= DONE;
                            busy_q   <= 1'b0;
                            done_q   <= 1'b1;
                            done_cnt <= '0;
                        end
                    end
                end

                DONE: begin
                    if (done_cnt == DONE_END) begin
                        state  <= IDLE;
                        done_q <= 1'b0;
                    end else begin
                        done_cnt <= done_cnt + DONE_INC;
                    end
                end

                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

endmodule : iob_modcnt_ctrl
